// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op types, FSM states, lane helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   function automatic logic is_store(op_e op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   function automatic logic is_aligned(op_e op, logic [1:0] off);
      case (op)
         OP_LW, OP_SW:         return (off == 2'b00);
         OP_LH, OP_LHU, OP_SH: return ~off[0];
         default:              return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(op_e op, logic [1:0] off);
      case (op)
         OP_LW, OP_SW:         return 4'b1111;
         OP_LH, OP_LHU, OP_SH: return 4'b0011 << off;
         default:              return 4'b0001 << off;
      endcase
   endfunction

   // Store data is right-aligned; copy it into every lane so the enables pick it.
   function automatic logic [31:0] store_lanes(op_e op, logic [31:0] wd);
      case (op)
         OP_SH:   return {2{wd[15:0]}};
         OP_SB:   return {4{wd[7:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Pure combinational lane select and sign/zero extension of a loaded word.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign lane_b = word[{byte_off, 3'b000} +: 8];
   assign lane_h = byte_off[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = word;
      case (op)
         OP_LB:   data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  data = {24'h0, lane_b};
         OP_LH:   data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  data = {16'h0, lane_h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding op, IDLE -> REQ -> (WAIT) -> IDLE.
// Misaligned ops fault in IDLE without touching memory; loads time out in WAIT.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wd,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rd
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_e        state, state_n;
   op_e           op_q;
   logic [31:0]   addr_q, wdata_q;
   logic [CW-1:0] cnt;
   logic          aligned, accept, ld_done, tmo;
   logic [31:0]   ext_data;

   assign aligned = is_aligned(op_e'(op_type), addr[1:0]);
   assign accept  = (state == ST_IDLE) && op_valid && aligned;
   assign ld_done = (state == ST_WAIT) && mem_rvalid;
   // A response on the final count still completes the load.
   assign tmo     = (state == ST_WAIT) && !mem_rvalid && (cnt == CW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         op_q    <= OP_LW;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_q    <= op_e'(op_type);
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state == ST_REQ)
            cnt <= '0;
         else if (state == ST_WAIT)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept)          state_n = ST_REQ;
         ST_REQ:  if (mem_gnt)         state_n = is_store(op_q) ? ST_IDLE : ST_WAIT;
         ST_WAIT: if (ld_done || tmo)  state_n = ST_IDLE;
         default:                      state_n = ST_IDLE;
      endcase
   end

   assign stall       = accept || (state != ST_IDLE);
   assign addr_err    = (state == ST_IDLE) && op_valid && !aligned;
   assign mem_req     = (state == ST_REQ);
   assign mem_we      = mem_req && is_store(op_q);
   assign mem_addr    = mem_req ? {addr_q[31:2], 2'b00} : '0;
   assign mem_be      = mem_req ? byte_en(op_q, addr_q[1:0]) : '0;
   assign mem_wd      = mem_we ? store_lanes(op_q, wdata_q) : '0;
   assign rdata_valid = ld_done;
   assign rdata       = ld_done ? ext_data : '0;
   assign bus_err     = tmo;

   lsu_load_ext u_load_ext (
      .op       (op_q),
      .byte_off (addr_q[1:0]),
      .word     (mem_rd),
      .data     (ext_data)
   );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with expected memory requests and load results queued.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op_type;
   logic [31:0] addr, wdata;
   logic        stall, rdata_valid, addr_err, bus_err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wd;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rd;

   int checks = 0;
   int errors = 0;
   int stall_cnt;
   req_t        req_q[$];
   logic [31:0] rd_q[$];

   lsu_ctrl #(.TIMEOUT(255)) dut (
      .clk         (clk),
      .reset       (reset),
      .op_valid    (op_valid),
      .op_type     (op_type),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .addr_err    (addr_err),
      .bus_err     (bus_err),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wd      (mem_wd),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rd      (mem_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      op_valid = 1'b0; op_type = 3'd0; addr = '0; wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rd = '0;
   endtask

   // Issue one op, grant after gnt_dly REQ cycles, answer a load after rv_dly WAIT cycles.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input int gnt_dly, input int rv_dly);
      logic is_ld;
      req_t r;
      is_ld = (op < 3'd5);
      @(posedge clk); #1;
      op_valid = 1'b1; op_type = op; addr = a; wdata = wd;
      req_q.push_back('{we: ~is_ld, a: {a[31:2], 2'b00}, be: exp_be, wd: exp_wd});
      if (is_ld) rd_q.push_back(exp_rd);
      stall_cnt = 0;
      @(negedge clk);
      chk({tag, "_accept_stall"}, stall, 1);
      chk({tag, "_accept_noreq"}, mem_req, 0);
      if (stall) stall_cnt++;
      for (int i = 0; i <= gnt_dly; i++) begin
         @(posedge clk); #1;
         op_valid = 1'b0;
         mem_gnt = (i == gnt_dly);
         mem_rvalid = (i == gnt_dly);
         mem_rd = 32'hBAD0_BAD0;
         @(negedge clk);
         if (stall) stall_cnt++;
         if (i == gnt_dly) begin
            chk({tag, "_mem_req"}, mem_req, 1);
            chk({tag, "_rvalid_in_gnt_ignored"}, rdata_valid, 0);
            chk({tag, "_req_q_size"}, req_q.size(), 1);
            if (req_q.size() > 0) begin
               r = req_q.pop_front();
               chk({tag, "_mem_we"}, mem_we, r.we);
               chk({tag, "_mem_addr"}, mem_addr, r.a);
               chk({tag, "_mem_be"}, mem_be, r.be);
               if (r.we) chk({tag, "_mem_wd"}, mem_wd, r.wd);
            end
         end
      end
      if (is_ld) begin
         for (int j = 0; j <= rv_dly; j++) begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = (j == rv_dly);
            mem_rd = (j == rv_dly) ? rd : 32'hBAD0_BAD0;
            op_valid = (j != rv_dly); op_type = OP_LW; addr = 32'h3;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (j == rv_dly) begin
               chk({tag, "_rdata_valid"}, rdata_valid, 1);
               chk({tag, "_no_bus_err"}, bus_err, 0);
               chk({tag, "_rd_q_size"}, rd_q.size(), 1);
               if (rd_q.size() > 0) chk({tag, "_rdata"}, rdata, rd_q.pop_front());
            end else if (j == 0) begin
               chk({tag, "_op_during_stall_ignored"}, addr_err, 0);
               chk({tag, "_wait_no_req"}, mem_req, 0);
            end
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk({tag, "_done_stall"}, stall, 0);
      chk({tag, "_done_req"}, mem_req, 0);
      chk({tag, "_done_rvld"}, rdata_valid, 0);
   endtask

   task automatic misaligned(input string tag, input logic [2:0] op, input logic [31:0] a);
      @(posedge clk); #1;
      op_valid = 1'b1; op_type = op; addr = a; wdata = 32'h5555_5555;
      @(negedge clk);
      chk({tag, "_addr_err"}, addr_err, 1);
      chk({tag, "_stall"}, stall, 0);
      chk({tag, "_mem_req"}, mem_req, 0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_addr_err_pulse"}, addr_err, 0);
      chk({tag, "_mem_req_after"}, mem_req, 0);
   endtask

   initial begin
      int n;
      logic seen;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_stall", stall, 0);
      chk("reset_req", mem_req, 0);
      chk("reset_we", mem_we, 0);
      chk("reset_be", mem_be, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_wd", mem_wd, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_flags", {rdata_valid, addr_err, bus_err}, 0);

      do_op("sw", OP_SW, 32'h10, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF, 0, 1, 0);
      chk("sw_stall_cycles", stall_cnt, 3);
      do_op("sb", OP_SB, 32'h13, 32'h0000_00AB, 0, 4'b1000, 32'hABAB_ABAB, 0, 0, 0);
      do_op("sh", OP_SH, 32'h12, 32'h1234_CAFE, 0, 4'b1100, 32'hCAFE_CAFE, 0, 2, 0);
      do_op("lb", OP_LB, 32'h21, 0, 32'h0000_8000, 4'b0010, 0, 32'hFFFF_FF80, 0, 1);
      do_op("lbu", OP_LBU, 32'h21, 0, 32'h0000_8000, 4'b0010, 0, 32'h0000_0080, 1, 0);
      do_op("lh", OP_LH, 32'h22, 0, 32'h8001_0000, 4'b1100, 0, 32'hFFFF_8001, 0, 2);
      do_op("lhu", OP_LHU, 32'h22, 0, 32'h8001_0000, 4'b1100, 0, 32'h0000_8001, 0, 0);
      do_op("lw", OP_LW, 32'h24, 0, 32'h1234_5678, 4'b1111, 0, 32'h1234_5678, 1, 3);
      misaligned("lw_mis", OP_LW, 32'h22);
      misaligned("sh_mis", OP_SH, 32'h11);

      // Stray responses while idle.
      @(posedge clk); #1;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rd = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("idle_stray_rvld", rdata_valid, 0);
      chk("idle_stray_req", mem_req, 0);
      chk("idle_stray_stall", stall, 0);
      @(posedge clk); #1;
      idle_inputs();

      // Load with no response: bus error after the full timeout window.
      @(posedge clk); #1;
      op_valid = 1'b1; op_type = OP_LW; addr = 32'h30;
      @(posedge clk); #1;
      op_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("tmo_mem_req", mem_req, 1);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (bus_err) seen = 1'b1;
         else begin
            n++;
            @(posedge clk); #1;
         end
      end
      chk("tmo_seen", seen, 1);
      chk("tmo_wait_cycles", n, 255);
      chk("tmo_rdata", rdata, 0);
      chk("tmo_stall_in_err", stall, 1);
      chk("tmo_no_rvld", rdata_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_stall_after", stall, 0);
      chk("tmo_err_pulse", bus_err, 0);

      // Response on the final count beats the timeout.
      do_op("lw_last", OP_LW, 32'h34, 0, 32'hCAFE_F00D, 4'b1111, 0, 32'hCAFE_F00D, 0, 255);

      // Reset while waiting abandons the load; the late response is ignored.
      @(posedge clk); #1;
      op_valid = 1'b1; op_type = OP_LW; addr = 32'h40;
      @(posedge clk); #1;
      op_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_rvalid = 1'b1; mem_rd = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("rst_wait_rvld", rdata_valid, 0);
      chk("rst_wait_stall", stall, 0);
      chk("rst_wait_req", mem_req, 0);
      chk("rst_wait_bus_err", bus_err, 0);
      chk("rst_wait_rdata", rdata, 0);
      chk("rst_wait_be", mem_be, 0);
      chk("rst_wait_addr", mem_addr, 0);
      @(posedge clk); #1;
      idle_inputs();

      chk("req_q_empty", req_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 op_valid  input  1  pipeline presents a memory op this cycle.
REQ-004 op_type  input  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7; 5'h? none else; values outside 0-7 are impossible by width.
REQ-005 addr  input  32  byte address of the op.
REQ-006 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 stall  output  1  holds pipeline; high while an op is accepted but not complete.
REQ-008 rdata  output  32  load result, sign/zero-extended per op_type.
REQ-009 rdata_valid  output  1  one-cycle pulse when rdata is valid.
REQ-010 addr_err  output  1  one-cycle pulse on misaligned op; no memory access issued.
REQ-011 bus_err  output  1  one-cycle pulse on response timeout.
REQ-012 mem_req  output  1  request to data memory.
REQ-013 mem_we  output  1  1=write, 0=read; valid while mem_req.
REQ-014 mem_addr  output  32  word-aligned address (addr[1:0] forced to 0).
REQ-015 mem_be  output  4  byte enables; bit i covers mem_wd[8i+7:8i].
REQ-016 mem_wd  output  32  store data replicated into enabled lanes.
REQ-017 mem_gnt  input  1  memory accepts request this cycle.
REQ-018 mem_rvalid  input  1  read data valid this cycle.
REQ-019 mem_rd  input  32  read data word.
REQ-020 TIMEOUT  parameter, default 255  max cycles in WAIT before bus_err.

Function
REQ-021 FSM states IDLE, REQ, WAIT; one op outstanding at most.
REQ-022 IDLE: op_valid and aligned -> latch op_type, addr, wdata, go REQ; stall asserted combinationally same cycle.
REQ-023 Alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0; byte ops always aligned.
REQ-024 Misaligned op in IDLE -> addr_err pulse that cycle, remain IDLE, stall low, mem_req never asserted.
REQ-025 REQ: mem_req=1 with stable mem_we/addr/be/wd until mem_gnt; no timeout in REQ.
REQ-026 REQ+mem_gnt, store -> IDLE, stall deasserted next cycle (store latency = grant cycle +1).
REQ-027 REQ+mem_gnt, load -> WAIT; mem_rvalid in the same cycle as mem_gnt is ignored.
REQ-028 WAIT: mem_rvalid -> rdata_valid pulse with extended data same cycle, -> IDLE.
REQ-029 WAIT: counter starts at 0 on entry, increments each cycle; reaching TIMEOUT without mem_rvalid -> bus_err pulse, rdata=0, -> IDLE; mem_rvalid on the TIMEOUT cycle wins over bus_err.
REQ-030 Byte enables: word 4'b1111; half 4'b0011<<addr[1:0]; byte 4'b0001<<addr[1:0]; loads also drive these.
REQ-031 Load extraction: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-032 mem_rvalid or mem_gnt arriving in IDLE is ignored.
REQ-033 op_valid while stall high is ignored (pipeline holds its op).

Reset
REQ-034 reset -> IDLE, counter 0, latches 0; all outputs 0 the cycle after reset is sampled.
REQ-035 reset mid-REQ/WAIT abandons the op with no rdata_valid/bus_err pulse; late mem_rvalid afterwards ignored per REQ-032.

Structure
REQ-036 op_type encodings and FSM state encodings live in shared package lsu_pkg.
REQ-037 Load extract/extend logic is sub-module lsu_load_ext (pure combinational); the rest is flat.

Verification
REQ-038 SW addr=0x10 wdata=0xDEADBEEF, mem_gnt after 2 cycles -> mem_be=4'b1111, mem_addr=0x10, stall high 3 cycles.
REQ-039 SB addr=0x13 wdata=0x000000AB -> mem_be=4'b1000, mem_wd=0xABABABAB.
REQ-040 LB addr=0x21, mem_rd=0x0000_80_00 -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 LH addr=0x22, mem_rd=0x8001_0000 -> rdata=0xFFFF8001; LW addr=0x22 -> addr_err pulse, mem_req stays 0.
REQ-042 LW granted, mem_rvalid withheld 255 cycles -> bus_err pulse, stall drops next cycle, rdata=0.
REQ-043 reset asserted in WAIT, then mem_rvalid -> no rdata_valid, FSM IDLE, all outputs 0.
